// File: rtl/reg_addr_mux.sv
// Register-address select mux feeding a 2-entry skid FIFO with valid/ready on both sides.
// Optional REG_ADDR_MUX_BYPASS_EN: an empty buffer forwards the request combinationally (0-cycle latency).
module reg_addr_mux #(
  parameter  int ADDR_W = 2,
  parameter  int NSRC   = 4,
  localparam int SEL_W  = $clog2(NSRC)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NSRC*ADDR_W-1:0]   addr_in,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     sel_err,
  output logic [7:0]               xfer_cnt
);

  logic              r_alive;
  logic [1:0]        r_count;
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [7:0]        r_xferCnt;
  logic [ADDR_W-1:0] r_memAddr [2];
  logic [SEL_W-1:0]  r_memSel  [2];
  logic              r_memErr  [2];

  logic [ADDR_W-1:0] w_selAddr;
  logic              w_selErr;
  logic              w_fifoValid;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_fifoPop;

  // Out-of-range selects yield address 0 and raise the error flag instead of indexing past addr_in.
  always_comb begin
    w_selAddr = '0;
    w_selErr  = (int'(sel) >= NSRC);
    for (int k = 0; k < NSRC; k++) begin
      if (int'(sel) == k) begin
        w_selAddr = addr_in[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_fifoValid = (r_count != 2'd0);

`ifdef REG_ADDR_MUX_BYPASS_EN
  assign w_bypass = r_alive && !w_fifoValid && in_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // r_alive keeps in_ready low on the first edge after reset so nothing is pushed there.
  assign in_ready  = r_alive && (r_count < 2'd2);
  assign out_valid = w_fifoValid || w_bypass;

  always_comb begin
    out     = '0;
    out_sel = '0;
    sel_err = 1'b0;
    if (w_bypass) begin
      out     = w_selAddr;
      out_sel = sel;
      sel_err = w_selErr;
    end else if (w_fifoValid) begin
      out     = r_memAddr[r_rdPtr];
      out_sel = r_memSel[r_rdPtr];
      sel_err = r_memErr[r_rdPtr];
    end
  end

  assign w_pop     = out_valid && out_ready;
  assign w_fifoPop = w_pop && w_fifoValid;
  assign w_push    = in_valid && in_ready && !(w_bypass && out_ready);
  assign xfer_cnt  = r_xferCnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alive   <= 1'b0;
      r_count   <= 2'd0;
      r_wrPtr   <= 1'b0;
      r_rdPtr   <= 1'b0;
      r_xferCnt <= 8'd0;
    end else begin
      r_alive <= 1'b1;
      case ({w_push, w_fifoPop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_wrPtr <= ~r_wrPtr;
      end
      if (w_fifoPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      if (w_pop) begin
        r_xferCnt <= r_xferCnt + 8'd1;
      end
    end
  end

  // Storage needs no reset: entries are only observable while the count says they are valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_memAddr[r_wrPtr] <= w_selAddr;
      r_memSel[r_wrPtr]  <= sel;
      r_memErr[r_wrPtr]  <= w_selErr;
    end
  end

endmodule

// File: tb/tb_reg_addr_mux.sv
// Randomized bench for reg_addr_mux, checked against a queue model; a second NSRC=3 instance covers select errors.
module tb_reg_addr_mux;

  localparam int ADDR_W = 2;
  localparam int NSRC   = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [7:0] addr_in;
  logic [1:0] sel, out_sel, out;
  logic [7:0] xfer_cnt;

  logic       in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
  logic [5:0] addr_in3;
  logic [1:0] sel3, out_sel3, out3;
  logic [7:0] xfer_cnt3;

  reg_addr_mux #(.ADDR_W(ADDR_W), .NSRC(NSRC)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .addr_in(addr_in), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_sel(out_sel), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
  );

  reg_addr_mux #(.ADDR_W(2), .NSRC(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .addr_in(addr_in3), .sel(sel3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out(out3), .out_sel(out_sel3), .sel_err(sel_err3), .xfer_cnt(xfer_cnt3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] addr;
    logic [1:0] sel;
    logic       err;
  } entry_t;

  int         testsRun  = 0;
  int         failCount = 0;
  entry_t     modelQ[$];
  logic [7:0] modelXfer = 8'd0;
  bit         modelAlive = 1'b0;

  function automatic entry_t expectedEntry(input logic [1:0] s, input logic [7:0] a);
    entry_t e;
    e.sel = s;
    if (int'(s) >= NSRC) begin
      e.err  = 1'b1;
      e.addr = 2'd0;
    end else begin
      e.err  = 1'b0;
      e.addr = 2'((a >> (int'(s) * ADDR_W)) & 8'h03);
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle, compare the outputs seen before the edge, then advance the model across the edge.
  task automatic applyStimulus(input logic iv, input logic ordy, input logic [1:0] s, input logic [7:0] a);
    entry_t head;
    bit     expValid, expReady, bypass, pop, push;
    @(negedge clock);
    in_valid  = iv;
    out_ready = ordy;
    sel       = s;
    addr_in   = a;
    #1;
    expReady = modelAlive && (modelQ.size() < 2);
    bypass   = 1'b0;
`ifdef REG_ADDR_MUX_BYPASS_EN
    bypass   = modelAlive && (modelQ.size() == 0) && iv;
`endif
    expValid = (modelQ.size() != 0) || bypass;
    head     = expectedEntry(2'd0, 8'd0);
    if (bypass) head = expectedEntry(s, a);
    else if (modelQ.size() != 0) head = modelQ[0];
    checkOutput("in_ready", in_ready, expReady);
    checkOutput("out_valid", out_valid, expValid);
    checkOutput("xfer_cnt", xfer_cnt, modelXfer);
    if (expValid) begin
      checkOutput("out", out, head.addr);
      checkOutput("out_sel", out_sel, head.sel);
      checkOutput("sel_err", sel_err, head.err);
    end
    pop  = expValid && ordy;
    push = iv && expReady;
    if (bypass && pop) push = 1'b0;
    if (pop && !bypass) void'(modelQ.pop_front());
    if (push) modelQ.push_back(expectedEntry(s, a));
    if (pop) modelXfer = modelXfer + 8'd1;
    @(posedge clock);
    modelAlive = 1'b1;
  endtask

  task automatic doReset();
    #2;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_xfer_cnt", xfer_cnt, 0);
    checkOutput("reset_out", out, 0);
    checkOutput("reset_out_sel", out_sel, 0);
    checkOutput("reset_sel_err", sel_err, 0);
    checkOutput("reset_out_valid3", out_valid3, 0);
    modelQ.delete();
    modelXfer  = 8'd0;
    modelAlive = 1'b0;
    @(negedge clock);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    sel      = 2'd1;
    addr_in  = 8'hFF;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    #1;
    checkOutput("first_edge_in_ready", in_ready, 1);
    checkOutput("first_edge_no_push", out_valid, 0);
    modelAlive = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    sel        = 2'd0;
    addr_in    = 8'd0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;
    sel3       = 2'd0;
    addr_in3   = 6'd0;

    doReset();

    // Two back-to-back transfers: source0 = 0, source1 = 1.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'b11_10_01_00);
    applyStimulus(1'b1, 1'b1, 2'd1, 8'b11_10_01_00);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
    #1;
    checkOutput("two_transfers", xfer_cnt, 8'd2);

    // Fill with out_ready low; third push must be refused and the head held.
    applyStimulus(1'b1, 1'b0, 2'd2, 8'b00_10_00_00);
    applyStimulus(1'b1, 1'b0, 2'd3, 8'b11_00_00_00);
    applyStimulus(1'b1, 1'b0, 2'd1, 8'b00_00_01_00);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    #1;
    checkOutput("full_head_held", out, 2'd2);
    checkOutput("full_in_ready", in_ready, 0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);

    // Simultaneous push and pop with one entry held.
    applyStimulus(1'b1, 1'b0, 2'd1, 8'b00_00_01_00);
    applyStimulus(1'b1, 1'b1, 2'd3, 8'b11_00_00_00);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);

    // Reset while holding two entries.
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h1B);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h2D);
    doReset();

    // NSRC = 3 instance: select 3 is out of range.
    in_valid3  = 1'b1;
    sel3       = 2'd3;
    addr_in3   = 6'h3F;
    out_ready3 = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    #1;
    in_valid3 = 1'b0;
    #1;
    checkOutput("nsrc3_valid", out_valid3, 1);
    checkOutput("nsrc3_err_out", out3, 2'd0);
    checkOutput("nsrc3_err_flag", sel_err3, 1);
    checkOutput("nsrc3_err_sel", out_sel3, 2'd3);
    sel3      = 2'd2;
    addr_in3  = 6'b10_01_11;
    in_valid3 = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    #1;
    in_valid3 = 1'b0;
    checkOutput("nsrc3_full", in_ready3, 0);
    out_ready3 = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    #1;
    out_ready3 = 1'b0;
    #1;
    checkOutput("nsrc3_second_out", out3, 2'd2);
    checkOutput("nsrc3_second_err", sel_err3, 0);
    checkOutput("nsrc3_second_sel", out_sel3, 2'd2);
    checkOutput("nsrc3_xfer", xfer_cnt3, 8'd1);

    // Sustained traffic long enough to wrap the transfer counter.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
    end

    // Random valid/ready mix.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                    2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
